ring_phase_monitor: RTL and testbench
=====================================

# ring_phase_monitor

Checker and decoder placed directly downstream of the 8-bit ring counter. It samples the counter's one-hot `count` bus every clock and encodes the hot bit to a binary phase index. It also verifies that each sample is the previous one rotated left by one, counts completed revolutions, and records rotation faults. It gives benches and downstream sequencing logic a registered phase index and a lock indication, and catches ring counters that break the one-hot pattern or stall.

## Interface
- `WIDTH`, 8: ring width. Must be ≥ 2.
- `PW`, $clog2(WIDTH): phase index width.
- `REV_W`, 16: revolution counter width.
- `LOCK_CYCLES`, 2: number of consecutive good rotation steps required to lock. Range 1..15.

Ports:
- `clk` in 1: single clock. Everything is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `count` in `WIDTH`: ring counter output, sampled every cycle.
- `clr_err` in 1: synchronous clear of `err` and `err_count`.
- `phase` out `PW`: index of the hot bit in the last valid one-hot sample.
- `phase_valid` out 1: last sample was one-hot.
- `locked` out 1: rotation tracking is established.
- `rev_tick` out 1: one-cycle pulse when a wrap is seen while locked.
- `rev_count` out `REV_W`: number of completed revolutions.
- `err` out 1: sticky fault flag.
- `err_count` out 8: number of faults, saturating.

## Operation
- `count_q` is the registered copy of `count`.
- `onehot` is true when exactly one bit of `count` is set.
- `step_ok` is true when `onehot` holds and `count == {count_q[WIDTH-2:0], count_q[WIDTH-1]}`.
- A repeated value (stall), a zero value, a multi-hot value, or a reverse rotation is not `step_ok`.
- `wrap` is true when `step_ok` holds and `count[0]` is set (the hot bit moved from `WIDTH-1` to 0).
- `phase` and `phase_valid` update every cycle when `count` is one-hot. When `count` is not one-hot, `phase_valid` goes to 0 and `phase` holds its last value.
- State machine, with a `good` counter of width 4:
  - IDLE: if `onehot`, go to TRACK with `good`=0. Otherwise stay in IDLE.
  - TRACK:
    - `step_ok`: increment `good`. If `good`+1 == `LOCK_CYCLES`, go to LOCKED.
    - One-hot but not `step_ok`: stay in TRACK and reset `good` to 0. This is a resync, not an error.
    - Not one-hot: go to IDLE.
  - LOCKED:
    - `step_ok`: stay in LOCKED. If `wrap` is also true, pulse `rev_tick` and increment `rev_count` (modulo 2^`REV_W`).
    - Any other sample is a fault: set `err`, increment `err_count` (saturating at 255), and go to FAULT.
  - FAULT: go to IDLE unconditionally after 1 cycle.
- `locked` is 1 exactly while the state is LOCKED.
- Wraps seen in IDLE or TRACK are not counted.
- `rev_count` is cleared only by `rst`. It holds its value through FAULT and relock.
- `clr_err`:
  - Clears `err` and `err_count` at the next edge.
  - If a fault occurs in the same cycle, the fault wins: `err`=1 and `err_count`=1.
- `rst` overrides everything, including a mid-lock or mid-fault state.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `count_q`=0, `phase`=0, `phase_valid`=0, `locked`=0, `rev_tick`=0, `rev_count`=0, `err`=0, `err_count`=0, `good`=0.
- `phase` and `phase_valid` have 1-cycle latency: they reflect `count` as sampled at the previous edge.
- Lock latency: with the first one-hot sample at edge N, `locked` rises after edge N+`LOCK_CYCLES`, provided every intermediate step is good.
- Fault response: on a bad sample at edge M, `locked` falls and `err` rises after edge M. The state is FAULT for cycle M+1 and IDLE after edge M+1. The earliest relock is after edge M+2+`LOCK_CYCLES`.
- `rev_tick` is high for exactly one cycle, in the same cycle that `rev_count` shows the incremented value.
- No combinational path from any input to any output.

## Test plan
- Reset: hold `rst` high for 2 cycles with `count`=8'hFF → every output is 0 and `locked` stays 0.
- Clean ring: drive 01,02,04,…,80,01,… one per cycle from edge 0 → `locked`=1 after edge 2 and `phase` follows 0..7. Each 80→01 produces one `rev_tick`; after 16 further steps, `rev_count`=2.
- Blocking-bug pattern, unlocked: drive 01,03,07,0F → `locked` stays 0 and `err` stays 0. `phase_valid` is 1 only after the first sample.
- Faults while locked:
  - Drive 10,10 (stall) → `err`=1, `err_count`=1, `locked` drops, then IDLE.
  - Resume a clean ring → relock after 2 good steps; `rev_count` keeps its value.
- Error bookkeeping:
  - Assert `clr_err` with no fault → `err`=0, `err_count`=0.
  - Assert `clr_err` in the same cycle as a fault → `err`=1, `err_count`=1.
  - Cause 300 faults → `err_count`=255.
- Reset mid-operation: assert `rst` while locked with `rev_count`=5 → all outputs 0 at the next edge. Release → relock per the lock-latency rule.

Source files
------------

// File: rtl/ring_phase_monitor.sv
// ring_phase_monitor
//   Sits behind a one-hot ring counter. It registers the ring value and
//   encodes the hot bit to a phase index. It checks that every sample is
//   the previous sample rotated left by one. Once a few good steps have
//   been seen it locks, counts revolutions, and flags any break in the
//   rotation as a sticky fault.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   count       ring counter bus, sampled every cycle
//   clr_err     clears err / err_count at the next edge (a same-cycle fault wins)
//   phase       index of the hot bit in the last one-hot sample
//   phase_valid last sample was one-hot
//   locked      rotation tracking established
//   rev_tick    one-cycle pulse on a wrap (WIDTH-1 -> 0) while locked
//   rev_count   completed revolutions, modulo 2^REV_W, cleared only by rst
//   err         sticky fault flag
//   err_count   fault count, saturating at 255
module ring_phase_monitor #(
   parameter int WIDTH       = 8,
   parameter int PW          = $clog2(WIDTH),
   parameter int REV_W       = 16,
   parameter int LOCK_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] count,
   input  logic             clr_err,
   output logic [PW-1:0]    phase,
   output logic             phase_valid,
   output logic             locked,
   output logic             rev_tick,
   output logic [REV_W-1:0] rev_count,
   output logic             err,
   output logic [7:0]       err_count
);

   typedef enum logic [1:0] {S_IDLE, S_TRACK, S_LOCKED, S_FAULT} state_t;

   state_t           state, state_d;
   logic [3:0]       good, good_d;
   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] rot;
   logic [PW-1:0]    enc;
   logic             onehot, step_ok, wrap, fault;

   // Exactly one bit set: nonzero, and clearing the lowest set bit leaves zero.
   assign onehot  = (count != '0) && ((count & (count - WIDTH'(1))) == '0);
   assign rot     = {count_q[WIDTH-2:0], count_q[WIDTH-1]};
   assign step_ok = onehot && (count == rot);
   assign wrap    = step_ok && count[0];

   always_comb begin
      enc = '0;
      for (int i = 0; i < WIDTH; i++)
         if (count[i]) enc = PW'(i);
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         good  <= '0;
      end else begin
         state <= state_d;
         good  <= good_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state;
      good_d  = good;
      fault   = 1'b0;
      case (state)
         S_IDLE: begin
            if (onehot) begin
               state_d = S_TRACK;
               good_d  = '0;
            end
         end
         S_TRACK: begin
            if (step_ok) begin
               good_d = good + 4'd1;
               if (good_d == 4'(LOCK_CYCLES)) state_d = S_LOCKED;
            end else if (onehot) begin
               // One-hot but not a rotation: resync, not a fault.
               good_d = '0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOCKED: begin
            if (!step_ok) begin
               fault   = 1'b1;
               state_d = S_FAULT;
            end
         end
         S_FAULT: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode (from the state register only)
   always_comb begin
      locked = (state == S_LOCKED);
   end

   // Registered datapath outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q     <= '0;
         phase       <= '0;
         phase_valid <= 1'b0;
         rev_tick    <= 1'b0;
         rev_count   <= '0;
         err         <= 1'b0;
         err_count   <= '0;
      end else begin
         count_q     <= count;
         phase_valid <= onehot;
         if (onehot) phase <= enc;

         // Wraps only count once tracking is locked.
         rev_tick <= (state == S_LOCKED) && wrap;
         if ((state == S_LOCKED) && wrap) rev_count <= rev_count + REV_W'(1);

         if (fault) begin
            err <= 1'b1;
            // A clear in the same cycle restarts the count at this fault.
            if (clr_err)                err_count <= 8'd1;
            else if (err_count != 8'hFF) err_count <= err_count + 8'd1;
         end else if (clr_err) begin
            err       <= 1'b0;
            err_count <= '0;
         end
      end
   end

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Bench for ring_phase_monitor (WIDTH=8, LOCK_CYCLES=2). Each step drives one
// sample, a reference model pushes the expected registered outputs to a queue,
// and after the edge the entry is popped and compared. Directed constant checks
// pin the key timing and boundary points.
module tb_ring_phase_monitor;

   logic        clk = 1'b0;
   logic        rst, clr_err;
   logic [7:0]  count;
   logic [2:0]  phase;
   logic        phase_valid, locked, rev_tick, err;
   logic [15:0] rev_count;
   logic [7:0]  err_count;

   ring_phase_monitor dut (
      .clk(clk), .rst(rst), .count(count), .clr_err(clr_err),
      .phase(phase), .phase_valid(phase_valid), .locked(locked),
      .rev_tick(rev_tick), .rev_count(rev_count), .err(err),
      .err_count(err_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]  ph;
      logic        pv;
      logic        lk;
      logic        tk;
      logic [15:0] rc;
      logic        er;
      logic [7:0]  ec;
   } obs_t;

   obs_t exp_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   // Reference model state: 0 idle, 1 track, 2 locked, 3 fault
   int          m_st   = 0;
   int          m_good = 0;
   logic [7:0]  m_prev = '0;
   logic [2:0]  m_ph   = '0;
   logic        m_pv   = 1'b0;
   logic        m_tk   = 1'b0;
   logic [15:0] m_rc   = '0;
   logic        m_er   = 1'b0;
   int          m_ec   = 0;

   task automatic model(input logic [7:0] c, input logic clr, input logic r);
      int   ones;
      logic oh, sok, flt;
      logic [7:0] rotv;
      if (r) begin
         m_st = 0; m_good = 0; m_prev = '0; m_ph = '0; m_pv = 0;
         m_tk = 0; m_rc = '0; m_er = 0; m_ec = 0;
         return;
      end
      ones = 0;
      for (int i = 0; i < 8; i++) if (c[i]) ones++;
      oh   = (ones == 1);
      rotv = {m_prev[6:0], m_prev[7]};
      sok  = oh && (c == rotv);
      flt  = 1'b0;
      m_tk = 1'b0;
      m_pv = oh;
      if (oh)
         for (int i = 0; i < 8; i++) if (c[i]) m_ph = 3'(i);
      case (m_st)
         0: if (oh) begin m_st = 1; m_good = 0; end
         1: begin
            if (sok) begin
               m_good++;
               if (m_good == 2) m_st = 2;
            end else if (oh) m_good = 0;
            else m_st = 0;
         end
         2: begin
            if (sok) begin
               if (c[0]) begin m_tk = 1'b1; m_rc = m_rc + 16'd1; end
            end else begin
               flt = 1'b1; m_st = 3;
            end
         end
         default: m_st = 0;
      endcase
      if (flt) begin
         m_er = 1'b1;
         m_ec = clr ? 1 : ((m_ec == 255) ? 255 : m_ec + 1);
      end else if (clr) begin
         m_er = 1'b0; m_ec = 0;
      end
      m_prev = c;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic step(input string tag, input logic [7:0] c,
                       input logic clr = 1'b0, input logic r = 1'b0);
      obs_t e, o;
      rst = r; count = c; clr_err = clr;
      model(c, clr, r);
      e.ph = m_ph; e.pv = m_pv; e.lk = (m_st == 2); e.tk = m_tk;
      e.rc = m_rc; e.er = m_er; e.ec = 8'(m_ec);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      o = {phase, phase_valid, locked, rev_tick, rev_count, err, err_count};
      n_cmp++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL sb_%s: observed %h expected %h (ph,pv,lk,tk,rc,er,ec)", tag, o, e);
      end
   endtask

   task automatic ring(input string tag, input logic [7:0] start, input int n);
      logic [7:0] v;
      v = start;
      repeat (n) begin
         step(tag, v);
         v = {v[6:0], v[7]};
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; clr_err = 1'b0; count = 8'hFF;

      // Reset with an all-ones bus
      step("rst", 8'hFF, 1'b0, 1'b1);
      step("rst", 8'hFF, 1'b0, 1'b1);
      chk("rst_outputs", 32'({phase, phase_valid, locked, rev_tick, rev_count, err, err_count}), 32'd0);

      // Clean ring: lock after edge 2, two wraps over the next 16 steps
      step("ring", 8'h01);
      step("ring", 8'h02);
      chk("lock_not_yet", 32'(locked), 32'd0);
      step("ring", 8'h04);
      chk("lock_latency", 32'(locked), 32'd1);
      chk("phase_2", 32'(phase), 32'd2);
      ring("ring", 8'h08, 14);
      chk("rev_count_2", 32'(rev_count), 32'd2);
      chk("rev_tick_wrap", 32'(rev_tick), 32'd1);
      chk("phase_wrap", 32'(phase), 32'd0);

      // Stall while locked
      ring("pre_stall", 8'h02, 4);
      step("stall", 8'h10);
      chk("stall_err", 32'(err), 32'd1);
      chk("stall_errc", 32'(err_count), 32'd1);
      chk("stall_unlock", 32'(locked), 32'd0);
      step("fault_cyc", 8'h20);
      chk("fault_unlocked", 32'(locked), 32'd0);

      // Relock; the wrap seen while tracking is not counted
      step("relock", 8'h40);
      step("relock", 8'h80);
      chk("relock_not_yet", 32'(locked), 32'd0);
      step("relock", 8'h01);
      chk("relock", 32'(locked), 32'd1);
      chk("rev_kept", 32'(rev_count), 32'd2);

      // Clear in the same cycle as a fault: fault wins, count restarts at 1
      step("locked", 8'h02);
      step("clr_fault", 8'h02, 1'b1);
      chk("clr_fault_err", 32'(err), 32'd1);
      chk("clr_fault_errc", 32'(err_count), 32'd1);
      step("fault_cyc", 8'h00);
      ring("relock2", 8'h01, 3);
      chk("relock2", 32'(locked), 32'd1);

      // Clear with no fault
      step("clr", 8'h08, 1'b1);
      chk("clr_err", 32'(err), 32'd0);
      chk("clr_errc", 32'(err_count), 32'd0);
      chk("clr_locked", 32'(locked), 32'd1);

      // Accumulating pattern while unlocked: never locks, never faults
      step("rst", 8'h00, 1'b0, 1'b1);
      step("blk", 8'h01);
      chk("blk_pv1", 32'(phase_valid), 32'd1);
      step("blk", 8'h03);
      chk("blk_pv0", 32'(phase_valid), 32'd0);
      step("blk", 8'h07);
      step("blk", 8'h0F);
      chk("blk_locked", 32'(locked), 32'd0);
      chk("blk_err", 32'(err), 32'd0);
      chk("blk_phase_hold", 32'(phase), 32'd0);

      // 300 faults saturate the counter
      repeat (300) begin
         ring("sat", 8'h01, 3);
         step("sat_fault", 8'h00);
         step("sat_fcyc", 8'h00);
      end
      chk("errc_sat", 32'(err_count), 32'd255);
      chk("err_sat", 32'(err), 32'd1);

      // Reset while locked with five revolutions counted
      step("rst", 8'h00, 1'b0, 1'b1);
      ring("rev5", 8'h01, 41);
      chk("rev5", 32'(rev_count), 32'd5);
      chk("rev5_locked", 32'(locked), 32'd1);
      step("rst_mid", 8'h02, 1'b0, 1'b1);
      chk("rst_mid_outputs", 32'({phase, phase_valid, locked, rev_tick, rev_count, err, err_count}), 32'd0);
      step("post_rst", 8'h04);
      step("post_rst", 8'h08);
      chk("post_rst_not_yet", 32'(locked), 32'd0);
      step("post_rst", 8'h10);
      chk("post_rst_lock", 32'(locked), 32'd1);
      chk("post_rst_phase", 32'(phase), 32'd4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
